// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register interface.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Bit counter holds 0..8 within a byte/ack slot
  localparam int BCNT_W = 4;
  typedef logic [BCNT_W-1:0] bcnt_t;

endpackage

// File: rtl/i2c_target_regif_if.sv
// Register bus between the I2C target and the fabric register file.
interface i2c_target_regif_if #(parameter int ADDR_W = 4);
  logic              WR_STRB;
  logic [ADDR_W-1:0] WR_ADDR;
  logic [7:0]        WR_DATA;
  logic [ADDR_W-1:0] RD_ADDR;
  logic [7:0]        RD_DATA;

  modport master (output WR_STRB, WR_ADDR, WR_DATA, RD_ADDR, input RD_DATA);
  modport slave  (input WR_STRB, WR_ADDR, WR_DATA, RD_ADDR, output RD_DATA);
endinterface

// File: rtl/i2c_line_filter.sv
// Pad line conditioning: 2-flop sync, FILT_LEN persistence filter, edge pulses.
// Edge pulses appear 2+FILT_LEN cycles after the raw line settles.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt;
  logic             filt_q;

  // Lines idle high, so reset to the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      cnt    <= '0;
      filt   <= 1'b1;
      filt_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], raw};
      filt_q <= filt;
      if (sync_q[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
        filt <= sync_q[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise = filt & ~filt_q;
  assign fall = ~filt & filt_q;

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target engine with an auto-incrementing register pointer on a simple register bus.
// SDA_OE changes only on filtered SCL falls; no clock stretching.
module i2c_target_regif
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h7E,
  parameter int         ADDR_W   = 4,
  parameter int         FILT_LEN = 4
) (
  input  logic CLK40,
  input  logic RST,
  input  logic SCL_IN,
  input  logic SDA_IN,
  output logic SDA_OE,
  output logic BUSY,
  output logic NACK_ERR,
  i2c_target_regif_if.master regs
);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
  logic sda_bit, start_det, stop_det, scl_evt;
  logic [7:0] byte_in;

  i2c_state_t        state, state_n;
  bcnt_t             bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              rw, rw_n, first_byte, first_n;
  logic [ADDR_W-1:0] ptr, ptr_n, wr_addr, wr_addr_n;
  logic [7:0]        wr_data, wr_data_n;
  logic              sda_oe, sda_oe_n, busy, busy_n, wr_strb, wr_strb_n, nack, nack_n;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl (
    .clk(CLK40), .rst(RST), .raw(SCL_IN), .filt(scl), .rise(scl_rise), .fall(scl_fall));
  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda (
    .clk(CLK40), .rst(RST), .raw(SDA_IN), .filt(sda), .rise(sda_rise), .fall(sda_fall));

  // A coincident SDA edge counts as happening after SCL: sample its old level, decode no START/STOP
  assign scl_evt   = scl_rise | scl_fall;
  assign sda_bit   = sda_rise ? 1'b0 : (sda_fall ? 1'b1 : sda);
  assign start_det = sda_fall & scl & ~scl_evt;
  assign stop_det  = sda_rise & scl & ~scl_evt;
  assign byte_in   = {shreg[6:0], sda_bit};

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    rw_n      = rw;
    first_n   = first_byte;
    ptr_n     = ptr;
    sda_oe_n  = sda_oe;
    busy_n    = busy;
    wr_strb_n = 1'b0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    nack_n    = 1'b0;
    if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      busy_n    = 1'b0;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_WR_BYTE: begin
          if (scl_rise) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + bcnt_t'(1);
            if (bit_cnt == bcnt_t'(7)) begin
              if (state == ST_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  rw_n   = byte_in[0];
                  busy_n = 1'b1;
                end else begin
                  state_n = ST_IGNORE;
                end
              end else if (first_byte) begin
                ptr_n   = byte_in[ADDR_W-1:0];
                first_n = 1'b0;
              end else begin
                wr_strb_n = 1'b1;
                wr_addr_n = ptr;
                wr_data_n = byte_in;
                ptr_n     = ptr + PTR_ONE;
              end
            end
          end else if (scl_fall && bit_cnt == bcnt_t'(8)) begin
            sda_oe_n  = ~I2C_ACK;
            bit_cnt_n = '0;
            state_n   = (state == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = '0;
            if (!rw) begin
              sda_oe_n = 1'b0;
              first_n  = 1'b1;
              state_n  = ST_WR_BYTE;
            end else begin
              shreg_n  = regs.RD_DATA;
              ptr_n    = ptr + PTR_ONE;
              sda_oe_n = ~regs.RD_DATA[7];
              state_n  = ST_RD_BYTE;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            state_n  = ST_WR_BYTE;
          end
        end
        ST_RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == bcnt_t'(7)) begin
              sda_oe_n  = 1'b0;
              bit_cnt_n = '0;
              state_n   = ST_RD_ACK;
            end else begin
              bit_cnt_n = bit_cnt + bcnt_t'(1);
              shreg_n   = {shreg[6:0], shreg[7]};
              sda_oe_n  = ~shreg[6];
            end
          end
        end
        ST_RD_ACK: begin
          // bit_cnt==1 marks an ACK seen on the rise
          if (scl_rise) begin
            if (sda_bit == I2C_NACK) begin
              nack_n   = 1'b1;
              sda_oe_n = 1'b0;
              state_n  = ST_IGNORE;
            end else begin
              bit_cnt_n = bcnt_t'(1);
            end
          end else if (scl_fall && bit_cnt == bcnt_t'(1)) begin
            shreg_n   = regs.RD_DATA;
            ptr_n     = ptr + PTR_ONE;
            sda_oe_n  = ~regs.RD_DATA[7];
            bit_cnt_n = '0;
            state_n   = ST_RD_BYTE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK40) begin
    if (RST) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      rw         <= 1'b0;
      first_byte <= 1'b0;
      ptr        <= '0;
      sda_oe     <= 1'b0;
      busy       <= 1'b0;
      wr_strb    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      nack       <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      rw         <= rw_n;
      first_byte <= first_n;
      ptr        <= ptr_n;
      sda_oe     <= sda_oe_n;
      busy       <= busy_n;
      wr_strb    <= wr_strb_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      nack       <= nack_n;
    end
  end

  assign SDA_OE       = sda_oe;
  assign BUSY         = busy;
  assign NACK_ERR     = nack;
  assign regs.WR_STRB = wr_strb;
  assign regs.WR_ADDR = wr_addr;
  assign regs.WR_DATA = wr_data;
  assign regs.RD_ADDR = ptr;

endmodule

// File: tb/tb_i2c_target_regif.sv
// Directed and randomized I2C master transactions against a register-file reference model.
module tb_i2c_target_regif;
  import i2c_pkg::*;

  localparam int AW   = 4;
  localparam int NREG = 1 << AW;
  localparam int H    = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  logic sda_oe, busy, nack_err, sda_line;

  logic [7:0]    fab_mem [NREG];
  logic [7:0]    model_mem [NREG];
  int            model_ptr = 0;
  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_wa = '0;
  logic [7:0]    tb_wd = '0;

  logic [AW-1:0] st_addr[$];
  logic [7:0]    st_data[$];
  int st_rd = 0;
  int nack_cnt = 0;
  int oe_cnt = 0;
  int compared = 0;
  int mismatched = 0;

  i2c_target_regif_if #(.ADDR_W(AW)) rif ();

  i2c_target_regif #(.DEV_ADDR(7'h7E), .ADDR_W(AW), .FILT_LEN(4)) dut (
    .CLK40(clk), .RST(rst), .SCL_IN(scl), .SDA_IN(sda_line),
    .SDA_OE(sda_oe), .BUSY(busy), .NACK_ERR(nack_err), .regs(rif.master));

  always #5 clk = ~clk;

  assign sda_line    = ~(m_low | sda_oe);
  assign rif.RD_DATA = fab_mem[rif.RD_ADDR];

  always @(posedge clk) begin
    if (tb_we) fab_mem[tb_wa] <= tb_wd;
    else if (rif.WR_STRB) fab_mem[rif.WR_ADDR] <= rif.WR_DATA;
  end

  always @(negedge clk) begin
    if (nack_err) nack_cnt++;
    if (sda_oe) oe_cnt++;
    if (rif.WR_STRB) begin
      st_addr.push_back(rif.WR_ADDR);
      st_data.push_back(rif.WR_DATA);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic v, output logic s);
    tick(H/2); m_low = ~v;
    tick(H/2); scl = 1'b1;
    tick(H/2); s = sda_line;
    tick(H/2); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (!scl) begin
      tick(H/2); m_low = 1'b0;
      tick(H/2); scl = 1'b1;
      tick(H/2);
    end
    m_low = 1'b1;
    tick(H/2); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(H/2); m_low = 1'b1;
    tick(H/2); scl = 1'b1;
    tick(H/2); m_low = 1'b0;
    tick(H/2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_line);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack_line);
  endtask

  task automatic recv_byte(input logic master_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(master_ack, s);
  endtask

  // Write transaction: pointer byte then data; model predicts strobes and pointer
  task automatic do_write(input string tag, input int k, input logic [7:0] d[$]);
    logic a;
    int base;
    base = st_addr.size();
    i2c_start();
    send_byte(8'hFC, a); check({tag, "_addr_ack"}, a, I2C_ACK);
    send_byte(8'(k), a); check({tag, "_ptr_ack"}, a, I2C_ACK);
    foreach (d[j]) begin
      send_byte(d[j], a); check({tag, "_data_ack"}, a, I2C_ACK);
    end
    check({tag, "_busy"}, busy, 1'b1);
    i2c_stop();
    check({tag, "_strobe_cnt"}, st_addr.size() - base, d.size());
    model_ptr = k % NREG;
    foreach (d[j]) begin
      if (base + j < st_addr.size()) begin
        check({tag, "_wr_addr"}, st_addr[base + j], model_ptr);
        check({tag, "_wr_data"}, st_data[base + j], d[j]);
      end
      model_mem[model_ptr] = d[j];
      model_ptr = (model_ptr + 1) % NREG;
    end
    st_rd = st_addr.size();
    check({tag, "_busy_after_stop"}, busy, 1'b0);
    check({tag, "_rd_addr"}, rif.RD_ADDR, model_ptr);
  endtask

  // Read n bytes from pointer k via repeated START; last byte NACKed
  task automatic do_read(input string tag, input int k, input int n);
    logic a;
    logic [7:0] b;
    int nk0;
    nk0 = nack_cnt;
    i2c_start();
    send_byte(8'hFC, a); check({tag, "_addr_ack"}, a, I2C_ACK);
    send_byte(8'(k), a); check({tag, "_ptr_ack"}, a, I2C_ACK);
    i2c_start();
    send_byte(8'hFD, a); check({tag, "_rd_addr_ack"}, a, I2C_ACK);
    model_ptr = k % NREG;
    for (int j = 0; j < n; j++) begin
      recv_byte((j == n - 1) ? I2C_NACK : I2C_ACK, b);
      check({tag, "_rd_data"}, b, model_mem[model_ptr]);
      model_ptr = (model_ptr + 1) % NREG;
    end
    i2c_stop();
    check({tag, "_nack_pulses"}, nack_cnt - nk0, 1);
    check({tag, "_rd_addr"}, rif.RD_ADDR, model_ptr);
  endtask

  initial begin
    logic a;
    logic [7:0] b;
    logic [7:0] dq[$];
    int oe0, st0, k, n, p;

    for (int i = 0; i < NREG; i++) begin
      model_mem[i] = 8'(($urandom & 32'hF0) | i);
      tb_we = 1'b1; tb_wa = AW'(i); tb_wd = model_mem[i];
      tick(1);
    end
    tb_we = 1'b0;
    tick(2);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_wr_strb", rif.WR_STRB, 1'b0);
    check("rst_wr_addr", rif.WR_ADDR, 0);
    check("rst_wr_data", rif.WR_DATA, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_nack_err", nack_err, 1'b0);
    check("rst_rd_addr", rif.RD_ADDR, 0);
    rst = 1'b0;
    tick(10);

    dq = '{8'hA5, 8'h5A};
    do_write("t1", 3, dq);

    do_read("t2", 14, 3);

    // Address 0xA2 does not match: no ACK, no strobe, never drives SDA
    oe0 = oe_cnt; st0 = st_addr.size();
    i2c_start();
    send_byte(8'hA2, a); check("t3_addr_nack", a, I2C_NACK);
    check("t3_busy", busy, 1'b0);
    send_byte(8'h11, a); check("t3_d0_nack", a, I2C_NACK);
    send_byte(8'h22, a); check("t3_d1_nack", a, I2C_NACK);
    i2c_stop();
    check("t3_sda_oe_cycles", oe_cnt - oe0, 0);
    check("t3_no_strobe", st_addr.size() - st0, 0);

    // 2-cycle SDA glitch with SCL high, then a bare 0xFC must not be ACKed
    oe0 = oe_cnt;
    tick(10);
    m_low = 1'b1; tick(2); m_low = 1'b0; tick(1);
    scl = 1'b0;
    send_byte(8'hFC, a); check("t4_no_start_ack", a, I2C_NACK);
    check("t4_busy", busy, 1'b0);
    check("t4_sda_oe_cycles", oe_cnt - oe0, 0);
    i2c_stop();

    // Reset during the 5th bit of a read byte while SDA is pulled low
    do p = $urandom_range(0, NREG - 1); while (model_mem[p][3] != 1'b0);
    i2c_start();
    send_byte(8'hFC, a); check("t5_addr_ack", a, I2C_ACK);
    send_byte(8'(p), a); check("t5_ptr_ack", a, I2C_ACK);
    i2c_start();
    send_byte(8'hFD, a); check("t5_rd_addr_ack", a, I2C_ACK);
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, a);
      check("t5_rd_bit", a, model_mem[p][7 - i]);
    end
    tick(H/2);
    check("t5_sda_oe_before_rst", sda_oe, 1'b1);
    rst = 1'b1;
    tick(1);
    check("t5_sda_oe_after_rst", sda_oe, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_rd_addr", rif.RD_ADDR, 0);
    check("t5_wr_addr", rif.WR_ADDR, 0);
    check("t5_wr_data", rif.WR_DATA, 0);
    check("t5_wr_strb", rif.WR_STRB, 1'b0);
    check("t5_nack_err", nack_err, 1'b0);
    tick(2);
    rst = 1'b0;
    model_ptr = 0;
    i2c_start();
    send_byte(8'hFC, a); check("t5_post_rst_ack", a, I2C_ACK);
    i2c_stop();

    // STOP at bit 4 of a data byte: no strobe, pointer from the first byte survives
    k = $urandom_range(0, NREG - 1);
    st0 = st_addr.size();
    i2c_start();
    send_byte(8'hFC, a); check("t6_addr_ack", a, I2C_ACK);
    send_byte(8'(k), a); check("t6_ptr_ack", a, I2C_ACK);
    b = 8'($urandom);
    for (int i = 7; i >= 4; i--) clock_bit(b[i], a);
    i2c_stop();
    check("t6_no_strobe", st_addr.size() - st0, 0);
    check("t6_rd_addr", rif.RD_ADDR, k);
    i2c_start();
    send_byte(8'hFD, a); check("t6_rd_ack", a, I2C_ACK);
    recv_byte(I2C_ACK, b); check("t6_rd0", b, model_mem[k]);
    recv_byte(I2C_NACK, b); check("t6_rd1", b, model_mem[(k + 1) % NREG]);
    i2c_stop();
    check("t6_ptr_after", rif.RD_ADDR, (k + 2) % NREG);

    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(0, NREG - 1);
      n = $urandom_range(1, 3);
      dq.delete();
      for (int j = 0; j < n; j++) dq.push_back(8'($urandom));
      do_write("rnd_wr", k, dq);
      do_read("rnd_rd", k, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_target_regif.md
Name: i2c_target_regif

Overview:
- Synthesizable I2C target (responder) engine for the DCFEB fabric. It is the other end of the optical-link and NVIO I2C masters in I2C_interfaces.
- Oversamples SCL/SDA on CLK40, decodes START/STOP, address, write and read transfers, and drives SDA open-drain.
- Exposes a simple register bus (write strobe, read address/data) with an auto-incrementing register pointer.
- Lets DCFEB-side logic act as an addressable I2C device, e.g. a loopback target on the DAQ/TRG link buses.

Parameters:
- DEV_ADDR, 7'h7E, 7-bit device address; 8-bit write address 0xFC.
- ADDR_W, 4, register pointer width; pointer wraps modulo 2^ADDR_W.
- FILT_LEN, 4, CLK40 samples a line must hold a new level before the filtered value changes.

Ports:
- CLK40  in  1  system clock, 40 MHz.
- RST  in  1  synchronous, active-high reset.
- SCL_IN  in  1  raw SCL pad input (asynchronous).
- SDA_IN  in  1  raw SDA pad input (asynchronous).
- SDA_OE  out  1  1 = pull SDA low. SDA is never driven high.
- WR_STRB  out  1  one-cycle register write pulse.
- WR_ADDR  out  ADDR_W  register address qualified by WR_STRB.
- WR_DATA  out  8  register data qualified by WR_STRB.
- RD_ADDR  out  ADDR_W  current pointer; the fabric returns data on RD_DATA combinationally.
- RD_DATA  in  8  register read data, sampled when a read byte is loaded.
- BUSY  out  1  high from address match until the next START or STOP.
- NACK_ERR  out  1  one-cycle pulse when the master NACKs a read byte.

Behaviour:
- Reset values: SDA_OE=0, WR_STRB=0, WR_ADDR=0, WR_DATA=0, BUSY=0, NACK_ERR=0, pointer=0, state=IDLE.
- RST has priority over any bus event. Reset mid-transfer releases SDA on the next cycle.
- Line conditioning, per line: 2-flop synchronizer, then a FILT_LEN-sample persistence filter, then an edge detector.
  - Filtered-edge latency: 2+FILT_LEN CLK40 cycles (6 by default).
  - All protocol decisions use filtered SCL/SDA and their edge pulses.
- START: filtered SDA falls while filtered SCL is high. Recognized in every state, including mid-byte (repeated start).
  - Action: bit counter=0, state=ADDR, SDA_OE=0, BUSY=0.
- STOP: filtered SDA rises while filtered SCL is high.
  - Action: state=IDLE, SDA_OE=0, BUSY=0. Pointer is retained.
- Bit timing: input bits are sampled on the SCL rising edge. SDA_OE changes only on the SCL falling edge; the filter delay provides hold time. No clock stretching.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR:
  - Shift 8 bits MSB first.
  - On the 8th rise: if bits[7:1]==DEV_ADDR, latch R/W and set BUSY=1. Otherwise go to IGNORE, which never drives SDA.
  - On the following fall: SDA_OE=1 and state=ADDR_ACK.
- ADDR_ACK: on the fall ending the 9th clock, SDA_OE=0.
  - If R/W=0: go to WR_BYTE; the first-byte flag is set.
  - If R/W=1: load shift register from RD_DATA (pointer at RD_ADDR), increment pointer, drive MSB (SDA_OE = ~bit7), go to RD_BYTE.
- WR_BYTE:
  - On the 8th rise, first byte after address: pointer = byte[ADDR_W-1:0]; no strobe.
  - On the 8th rise, later bytes: WR_STRB=1 for one cycle with WR_ADDR=pointer and WR_DATA=byte; pointer increments (wrapping) on the same cycle.
  - On the next fall: ACK (SDA_OE=1), go to WR_ACK.
  - Every byte is ACKed.
- WR_ACK: on the fall, release SDA and go back to WR_BYTE.
- RD_BYTE: on each fall, shift and drive the next bit. After the 8th bit's fall, release SDA and go to RD_ACK.
- RD_ACK: sample SDA on the rise.
  - 0 (ACK): on the next fall, load RD_DATA, increment pointer, drive MSB, go to RD_BYTE.
  - 1 (NACK): pulse NACK_ERR, go to IGNORE with SDA released.
- IGNORE: exit only on START or STOP.
- Pointer wraps 2^ADDR_W-1 -> 0 for both reads and writes.
- Simultaneous SCL and SDA edges in the same cycle: SDA is treated as changed after SCL. No START/STOP is decoded from it.

Decomposition:
- Shared package i2c_pkg:
  - state enum;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1;
  - bit-count width constant (4 bits, counts 0-8).
- One sub-module i2c_line_filter (synchronizer + FILT_LEN filter + rise/fall pulses), instantiated for SCL and for SDA.

Test Plan:
- Write 0xFC, 0x03, 0xA5, 0x5A → ACK on all 4 bytes; WR_STRB pulses at WR_ADDR=3 data 0xA5, then WR_ADDR=4 data 0x5A; BUSY=1 until STOP.
- Write 0xFC, 0x0E, then repeated START, 0xFD, read 3 bytes ACK, ACK, NACK, STOP → RD_ADDR sequence 0xE, 0xF, 0x0 (wrap); returned bytes match RD_DATA; NACK_ERR pulses once.
- Address 0xA2 (mismatch) followed by 2 data bytes → SDA_OE stays 0 throughout; no WR_STRB; BUSY=0.
- 2-cycle SDA glitch (<FILT_LEN) while SCL high in IDLE → no START detected; state stays IDLE.
- RST asserted during the 5th bit of a read byte with SDA_OE=1 → SDA_OE=0 the next cycle; all outputs at reset values; next START/0xFC is ACKed.
- STOP mid-write at bit 4 → state IDLE, no WR_STRB; a following read starts at the pointer value retained from the prior transaction.
